// File: rtl/call_stack_sequencer_if.sv
// Request/stack/redirect bundle between the decoder side (master) and the
// return-address stack sequencer (slave).
interface call_stack_sequencer_if #(
   parameter int ADDR_W  = 11,
   parameter int DEPTH_W = 3
);
   logic               call_req;
   logic               ret_req;
   logic [ADDR_W-1:0]  call_target;
   logic [ADDR_W-1:0]  pc;
   logic               irq;
   logic [ADDR_W-1:0]  irq_vector;
   logic [ADDR_W-1:0]  stk_rdata;
   logic [ADDR_W-1:0]  stk_wdata;
   logic               stk_store;
   logic               stk_load;
   logic               pc_load;
   logic [ADDR_W-1:0]  pc_next;
   logic               stall;
   logic               irq_ack;
   logic               in_isr;
   logic [DEPTH_W-1:0] depth;
   logic               fault;

   modport master (
      output call_req, ret_req, call_target, pc, irq, irq_vector, stk_rdata,
      input  stk_wdata, stk_store, stk_load, pc_load, pc_next, stall,
             irq_ack, in_isr, depth, fault
   );

   modport slave (
      input  call_req, ret_req, call_target, pc, irq, irq_vector, stk_rdata,
      output stk_wdata, stk_store, stk_load, pc_load, pc_next, stall,
             irq_ack, in_isr, depth, fault
   );
endinterface

// File: rtl/call_stack_sequencer.sv
// Return-address stack controller: arbitrates irq/RET/CALL, sequences push/pop
// strobes and PC redirect. Define STACK_GUARD_EN for overflow/underflow faulting.
module call_stack_sequencer #(
   parameter int ADDR_W  = 11,
   parameter int DEPTH   = 3,
   parameter int DEPTH_W = 3
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   call_stack_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PUSH  = 2'd1,
      ST_POP   = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

`ifdef STACK_GUARD_EN
   localparam logic GUARD_ON = 1'b1;
`else
   localparam logic GUARD_ON = 1'b0;
`endif

   state_t              r_state;
   logic [ADDR_W-1:0]   r_stk_wdata;
   logic [ADDR_W-1:0]   r_pc_next;
   logic                r_stk_store;
   logic                r_stk_load;
   logic                r_pc_load;
   logic                r_stall;
   logic                r_irq_ack;
   logic                r_in_isr;
   logic [DEPTH_W-1:0]  r_depth;
   logic                r_fault;

   logic                w_irq_go;
   logic                w_full;
   logic                w_empty;
   logic [ADDR_W-1:0]   w_ret_call;

   assign w_irq_go   = bus.irq & ~r_in_isr;
   assign w_full     = GUARD_ON & (r_depth == DEPTH_W'(DEPTH));
   assign w_empty    = GUARD_ON & (r_depth == {DEPTH_W{1'b0}});
   assign w_ret_call = bus.pc + ADDR_W'(1);

   // Single FSM: everything a PUSH/POP cycle shows is registered at the accept edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_stk_wdata <= {ADDR_W{1'b0}};
         r_pc_next   <= {ADDR_W{1'b0}};
         r_stk_store <= 1'b0;
         r_stk_load  <= 1'b0;
         r_pc_load   <= 1'b0;
         r_stall     <= 1'b0;
         r_irq_ack   <= 1'b0;
         r_in_isr    <= 1'b0;
         r_depth     <= {DEPTH_W{1'b0}};
         r_fault     <= 1'b0;
      end else begin
         r_stk_store <= 1'b0;
         r_stk_load  <= 1'b0;
         r_pc_load   <= 1'b0;
         r_irq_ack   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_irq_go) begin
                  r_stall <= 1'b1;
                  if (w_full) begin
                     r_state <= ST_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state     <= ST_PUSH;
                     r_stk_wdata <= bus.pc;
                     r_pc_next   <= bus.irq_vector;
                     r_stk_store <= 1'b1;
                     r_pc_load   <= 1'b1;
                     r_irq_ack   <= 1'b1;
                     r_in_isr    <= 1'b1;
                     r_depth     <= r_depth + DEPTH_W'(1);
                  end
               end else if (bus.ret_req) begin
                  r_stall <= 1'b1;
                  if (w_empty) begin
                     r_state <= ST_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     // Top of stack is captured before the pop edge removes it.
                     r_state    <= ST_POP;
                     r_pc_next  <= bus.stk_rdata;
                     r_stk_load <= 1'b1;
                     r_pc_load  <= 1'b1;
                     r_in_isr   <= 1'b0;
                     r_depth    <= r_depth - DEPTH_W'(1);
                  end
               end else if (bus.call_req) begin
                  r_stall <= 1'b1;
                  if (w_full) begin
                     r_state <= ST_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state     <= ST_PUSH;
                     r_stk_wdata <= w_ret_call;
                     r_pc_next   <= bus.call_target;
                     r_stk_store <= 1'b1;
                     r_pc_load   <= 1'b1;
                     r_depth     <= r_depth + DEPTH_W'(1);
                  end
               end else begin
                  r_stall <= 1'b0;
               end
            end
            ST_PUSH, ST_POP: begin
               r_state <= ST_IDLE;
               r_stall <= 1'b0;
            end
            ST_FAULT: begin
               r_stall <= 1'b1;
               r_fault <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_stall <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stk_wdata = r_stk_wdata;
   assign bus.stk_store = r_stk_store;
   assign bus.stk_load  = r_stk_load;
   assign bus.pc_load   = r_pc_load;
   assign bus.pc_next   = r_pc_next;
   assign bus.stall     = r_stall;
   assign bus.irq_ack   = r_irq_ack;
   assign bus.in_isr    = r_in_isr;
   assign bus.depth     = r_depth;
   assign bus.fault     = r_fault;
endmodule

// File: tb/tb_call_stack_sequencer.sv
// Directed self-checking bench for call_stack_sequencer; expectations follow
// STACK_GUARD_EN when it is defined for the build.
module tb_call_stack_sequencer;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   call_stack_sequencer_if #(.ADDR_W(11), .DEPTH_W(3)) bus ();

   call_stack_sequencer #(.ADDR_W(11), .DEPTH(3), .DEPTH_W(3)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.call_req = 1'b0;
      bus.ret_req  = 1'b0;
      bus.irq      = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.call_target = 11'h000;
      bus.pc          = 11'h000;
      bus.irq_vector  = 11'h000;
      bus.stk_rdata   = 11'h000;
      do_reset();
      checks++;
      if ({bus.stk_store, bus.stk_load, bus.pc_load, bus.stall, bus.irq_ack, bus.in_isr, bus.fault} !== 7'b0) begin
         errors++; $display("FAIL reset_flags got=%b exp=0000000", {bus.stk_store, bus.stk_load, bus.pc_load, bus.stall, bus.irq_ack, bus.in_isr, bus.fault});
      end
      checks++;
      if ({bus.depth, bus.stk_wdata, bus.pc_next} !== 25'h0) begin
         errors++; $display("FAIL reset_values got depth=%0d wdata=%h pc_next=%h exp 0", bus.depth, bus.stk_wdata, bus.pc_next);
      end
   endtask

   task automatic test_call();
      bus.pc = 11'h010; bus.call_target = 11'h200; bus.call_req = 1'b1;
      tick();
      bus.call_req = 1'b0;
      checks++; if (bus.stk_store !== 1'b1) begin errors++; $display("FAIL call_store got=%b exp=1", bus.stk_store); end
      checks++; if (bus.stk_wdata !== 11'h011) begin errors++; $display("FAIL call_wdata got=%h exp=011", bus.stk_wdata); end
      checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL call_pc_load got=%b exp=1", bus.pc_load); end
      checks++; if (bus.pc_next !== 11'h200) begin errors++; $display("FAIL call_pc_next got=%h exp=200", bus.pc_next); end
      checks++; if (bus.depth !== 3'd1) begin errors++; $display("FAIL call_depth got=%0d exp=1", bus.depth); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL call_stall_hi got=%b exp=1", bus.stall); end
      checks++; if (bus.stk_load !== 1'b0) begin errors++; $display("FAIL call_no_load got=%b exp=0", bus.stk_load); end
      tick();
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL call_stall_lo got=%b exp=0", bus.stall); end
      checks++; if ({bus.stk_store, bus.pc_load} !== 2'b00) begin errors++; $display("FAIL call_strobe_end got=%b exp=00", {bus.stk_store, bus.pc_load}); end
   endtask

   task automatic test_ret();
      bus.stk_rdata = 11'h011; bus.ret_req = 1'b1;
      tick();
      bus.ret_req = 1'b0;
      checks++; if (bus.stk_load !== 1'b1) begin errors++; $display("FAIL ret_load got=%b exp=1", bus.stk_load); end
      checks++; if (bus.pc_next !== 11'h011) begin errors++; $display("FAIL ret_pc_next got=%h exp=011", bus.pc_next); end
      checks++; if (bus.depth !== 3'd0) begin errors++; $display("FAIL ret_depth got=%0d exp=0", bus.depth); end
      checks++; if ({bus.stk_store, bus.pc_load} !== 2'b01) begin errors++; $display("FAIL ret_store_pcload got=%b exp=01", {bus.stk_store, bus.pc_load}); end
      tick();
      checks++; if (bus.stk_load !== 1'b0) begin errors++; $display("FAIL ret_load_end got=%b exp=0", bus.stk_load); end
   endtask

   task automatic test_priority();
      bus.pc = 11'h050; bus.irq_vector = 11'h100; bus.call_target = 11'h300; bus.stk_rdata = 11'h222;
      bus.irq = 1'b1; bus.ret_req = 1'b1; bus.call_req = 1'b1;
      tick();
      bus.irq = 1'b0;
      checks++; if ({bus.irq_ack, bus.stk_store, bus.in_isr} !== 3'b111) begin errors++; $display("FAIL prio_irq_flags got=%b exp=111", {bus.irq_ack, bus.stk_store, bus.in_isr}); end
      checks++; if (bus.stk_wdata !== 11'h050) begin errors++; $display("FAIL prio_irq_wdata got=%h exp=050", bus.stk_wdata); end
      checks++; if (bus.pc_next !== 11'h100) begin errors++; $display("FAIL prio_irq_pc_next got=%h exp=100", bus.pc_next); end
      tick();
      checks++; if ({bus.irq_ack, bus.stall} !== 2'b00) begin errors++; $display("FAIL prio_idle got=%b exp=00", {bus.irq_ack, bus.stall}); end
      tick();
      bus.ret_req = 1'b0;
      checks++; if ({bus.stk_load, bus.stk_store, bus.in_isr} !== 3'b100) begin errors++; $display("FAIL prio_ret_flags got=%b exp=100", {bus.stk_load, bus.stk_store, bus.in_isr}); end
      checks++; if (bus.pc_next !== 11'h222) begin errors++; $display("FAIL prio_ret_pc_next got=%h exp=222", bus.pc_next); end
      tick();
      tick();
      bus.call_req = 1'b0;
      checks++; if (bus.stk_store !== 1'b1) begin errors++; $display("FAIL prio_call_store got=%b exp=1", bus.stk_store); end
      checks++; if ({bus.stk_wdata, bus.pc_next} !== {11'h051, 11'h300}) begin errors++; $display("FAIL prio_call_addr got=%h/%h exp=051/300", bus.stk_wdata, bus.pc_next); end
      checks++; if (bus.depth !== 3'd1) begin errors++; $display("FAIL prio_call_depth got=%0d exp=1", bus.depth); end
      tick();
   endtask

   task automatic test_no_nest();
      do_reset();
      bus.pc = 11'h020; bus.irq_vector = 11'h100; bus.stk_rdata = 11'h020; bus.irq = 1'b1;
      tick();
      checks++; if (bus.irq_ack !== 1'b1) begin errors++; $display("FAIL nest_first_ack got=%b exp=1", bus.irq_ack); end
      tick();
      tick();
      checks++; if ({bus.irq_ack, bus.stk_store, bus.stall} !== 3'b000) begin errors++; $display("FAIL nest_blocked got=%b exp=000", {bus.irq_ack, bus.stk_store, bus.stall}); end
      bus.ret_req = 1'b1;
      tick();
      bus.ret_req = 1'b0;
      checks++; if ({bus.stk_load, bus.in_isr} !== 2'b10) begin errors++; $display("FAIL nest_ret got=%b exp=10", {bus.stk_load, bus.in_isr}); end
      tick();
      tick();
      bus.irq = 1'b0;
      checks++; if ({bus.irq_ack, bus.in_isr} !== 2'b11) begin errors++; $display("FAIL nest_reaccept got=%b exp=11", {bus.irq_ack, bus.in_isr}); end
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus.pc = 11'(i * 16); bus.call_target = 11'h400; bus.call_req = 1'b1;
         tick();
         bus.call_req = 1'b0;
         tick();
      end
      checks++; if (bus.depth !== 3'd3) begin errors++; $display("FAIL ovf_depth3 got=%0d exp=3", bus.depth); end
      bus.pc = 11'h123; bus.call_req = 1'b1;
      tick();
      bus.call_req = 1'b0;
`ifdef STACK_GUARD_EN
      checks++; if ({bus.stk_store, bus.pc_load} !== 2'b00) begin errors++; $display("FAIL ovf_no_strobe got=%b exp=00", {bus.stk_store, bus.pc_load}); end
      checks++; if ({bus.fault, bus.stall} !== 2'b11) begin errors++; $display("FAIL ovf_fault got=%b exp=11", {bus.fault, bus.stall}); end
      checks++; if (bus.depth !== 3'd3) begin errors++; $display("FAIL ovf_depth_hold got=%0d exp=3", bus.depth); end
      tick(); tick(); tick();
      checks++; if ({bus.fault, bus.stall, bus.stk_store} !== 3'b110) begin errors++; $display("FAIL ovf_stuck got=%b exp=110", {bus.fault, bus.stall, bus.stk_store}); end
      do_reset();
      checks++; if ({bus.fault, bus.stall, bus.depth} !== 5'b0) begin errors++; $display("FAIL ovf_reset got=%b exp=00000", {bus.fault, bus.stall, bus.depth}); end
`else
      checks++; if ({bus.stk_store, bus.pc_load} !== 2'b11) begin errors++; $display("FAIL ovf_strobe got=%b exp=11", {bus.stk_store, bus.pc_load}); end
      checks++; if (bus.depth !== 3'd4) begin errors++; $display("FAIL ovf_depth4 got=%0d exp=4", bus.depth); end
      checks++; if ({bus.stk_wdata, bus.fault} !== {11'h124, 1'b0}) begin errors++; $display("FAIL ovf_wdata got=%h fault=%b exp=124 0", bus.stk_wdata, bus.fault); end
      tick();
`endif
   endtask

   task automatic test_underflow();
      do_reset();
      bus.stk_rdata = 11'h0AA; bus.ret_req = 1'b1;
      tick();
      bus.ret_req = 1'b0;
`ifdef STACK_GUARD_EN
      checks++; if ({bus.stk_load, bus.pc_load} !== 2'b00) begin errors++; $display("FAIL unf_no_strobe got=%b exp=00", {bus.stk_load, bus.pc_load}); end
      checks++; if ({bus.fault, bus.stall} !== 2'b11) begin errors++; $display("FAIL unf_fault got=%b exp=11", {bus.fault, bus.stall}); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if ({bus.fault, bus.stall, bus.depth} !== 5'b0) begin errors++; $display("FAIL unf_reset got=%b exp=00000", {bus.fault, bus.stall, bus.depth}); end
      bus.pc = 11'h030; bus.call_req = 1'b1;
      tick();
      bus.call_req = 1'b0;
      checks++; if (bus.stk_store !== 1'b1) begin errors++; $display("FAIL unf_idle_again got=%b exp=1", bus.stk_store); end
      tick();
`else
      checks++; if ({bus.stk_load, bus.pc_load, bus.fault} !== 3'b110) begin errors++; $display("FAIL unf_pop got=%b exp=110", {bus.stk_load, bus.pc_load, bus.fault}); end
      checks++; if (bus.depth !== 3'd7) begin errors++; $display("FAIL unf_depth_wrap got=%0d exp=7", bus.depth); end
      tick();
`endif
   endtask

   task automatic test_pc_wrap();
      do_reset();
      bus.pc = 11'h7FF; bus.call_target = 11'h400; bus.call_req = 1'b1;
      tick();
      bus.call_req = 1'b0;
      checks++; if (bus.stk_wdata !== 11'h000) begin errors++; $display("FAIL wrap_wdata got=%h exp=000", bus.stk_wdata); end
      checks++; if (bus.pc_next !== 11'h400) begin errors++; $display("FAIL wrap_pc_next got=%h exp=400", bus.pc_next); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.pc = 11'h040; bus.call_target = 11'h500; bus.call_req = 1'b1;
      tick();
      bus.call_req = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if ({bus.stk_store, bus.pc_load, bus.stall, bus.depth} !== 6'b0) begin errors++; $display("FAIL mid_reset got=%b exp=000000", {bus.stk_store, bus.pc_load, bus.stall, bus.depth}); end
      checks++; if ({bus.stk_wdata, bus.pc_next} !== 22'h0) begin errors++; $display("FAIL mid_reset_addr got=%h/%h exp=0/0", bus.stk_wdata, bus.pc_next); end
      tick();
      checks++; if ({bus.stk_store, bus.stk_load, bus.pc_load} !== 3'b000) begin errors++; $display("FAIL mid_after got=%b exp=000", {bus.stk_store, bus.stk_load, bus.pc_load}); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      test_reset();
      test_call();
      test_ret();
      test_priority();
      test_no_nest();
      test_overflow();
      test_underflow();
      test_pc_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/call_stack_sequencer.md
# call_stack_sequencer

Controller for the return-address stack of the processor core. It accepts CALL and RET requests from the instruction decoder and interrupt entry requests, and arbitrates between them. It sequences the stack's store/load strobes and drives the program-counter redirect, and tracks stack depth with optional overflow/underflow guarding. It sits between the decoder/PC register and the 11-bit return-address stack.

## Interface
- ADDR_W, 11, program address width
- DEPTH, 3, stack capacity in entries
- DEPTH_W, 3, width of depth counter

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- call_req  in  1  decoder CALL request, held until accepted
- ret_req  in  1  decoder RET request, held until accepted
- call_target  in  ADDR_W  CALL destination address
- pc  in  ADDR_W  current program counter
- irq  in  1  interrupt request level
- irq_vector  in  ADDR_W  interrupt handler address
- stk_rdata  in  ADDR_W  top-of-stack value from the stack block (combinational)
- stk_wdata  out  ADDR_W  return address to push
- stk_store  out  1  push strobe, one cycle
- stk_load  out  1  pop strobe, one cycle
- pc_load  out  1  one-cycle PC redirect strobe
- pc_next  out  ADDR_W  redirect address, valid when pc_load=1
- stall  out  1  high while the controller is not in IDLE
- irq_ack  out  1  one-cycle interrupt acceptance pulse
- in_isr  out  1  interrupt handler active
- depth  out  DEPTH_W  current number of stacked entries
- fault  out  1  sticky stack fault

## Operation
- FSM states: IDLE, PUSH, POP, FAULT.
- IDLE arbitration, priority highest first:
  - irq, only if in_isr=0
  - ret_req
  - call_req
- One request is accepted per IDLE cycle. Losing requests stay pending.
- Accepted CALL:
  - latch target=call_target and ret=pc+1 (ADDR_W bits, wraps 0x7FF→0x000)
  - go to PUSH
- Accepted irq:
  - latch target=irq_vector and ret=pc (instruction not executed is re-run)
  - pulse irq_ack
  - set in_isr
  - go to PUSH
- PUSH: assert stk_store, stk_wdata=ret, pc_load=1, pc_next=target, depth+1, return to IDLE.
- Accepted RET: go to POP.
- POP: assert pc_load=1 with pc_next=stk_rdata (sampled before the pop edge), stk_load=1, depth−1, clear in_isr if set, return to IDLE.
- stk_store and stk_load are never high together.
- Requests seen outside IDLE are ignored and must be held by the requester.
- FAULT:
  - all strobes 0, stall=1, fault=1
  - exit only by reset

## Timing
- Request high in IDLE at cycle N:
  - cycle N+1: PUSH/POP with strobes and pc_load
  - cycle N+2: back in IDLE
- Throughput is one stack operation per 2 cycles.
- stall is registered: it goes high at N+1 and is low again at N+2.
- irq_ack is high in cycle N+1, together with stk_store.
- Reset values: state IDLE, depth=0, in_isr=0, fault=0, stall=0, all strobes 0, stk_wdata=0, pc_next=0.
- Reset asserted mid-operation, including the PUSH/POP cycle: the next edge forces the reset values. No strobe is issued in the cycle after reset.
- irq while in_isr=1: no nesting, stays pending until RET clears in_isr.

## Configuration
- STACK_GUARD_EN defined:
  - CALL/irq accepted at depth==DEPTH → FAULT, no strobe, no pc_load
  - RET accepted at depth==0 → FAULT, no strobe, no pc_load
- STACK_GUARD_EN undefined:
  - no check, operations always execute
  - depth wraps modulo 2^DEPTH_W
  - fault tied to 0, FAULT state unreachable

## Test plan
- Reset, then CALL with pc=0x010, call_target=0x200:
  - N+1: stk_store=1, stk_wdata=0x011, pc_load=1, pc_next=0x200, depth=1
  - N+2: stall=0
- With depth=1 and stk_rdata=0x011, RET → N+1: stk_load=1, pc_next=0x011, depth=0.
- irq, ret_req and call_req high together in IDLE with pc=0x050, irq_vector=0x100:
  - irq served first, with irq_ack=1, stk_wdata=0x050, pc_next=0x100, in_isr=1
  - RET next, then CALL after that
- Three CALLs then a fourth CALL:
  - with STACK_GUARD_EN: fault=1, no stk_store, stall stuck at 1 until reset
  - without: store issued, depth wraps 3→4
- RET at depth 0 with STACK_GUARD_EN → FAULT. Reset in the following cycle clears fault, depth=0, state IDLE.
- CALL with pc=0x7FF → stk_wdata=0x000.
